mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one single-port memory port between the fetch stage and the mem stage. The mem stage wins conflicts by default; a bounded starvation counter guarantees fetch forward progress. The arbiter routes one-cycle-latency read responses back to the owning requester and holds each requester's last read data stable. It sits between the pipeline stages and the unified-port memory.

## Interface
- `STARVE_LIMIT`, default 4: consecutive conflict cycles mem may win before fetch is forced; legal range 1..15.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `fe_req` in 1: fetch request; held until `fe_ack`.
- `fe_addr` in 30 ([31:2]): fetch word address.
- `fe_ack` out 1: fetch request accepted this cycle.
- `fe_error` out 1: fetch access fault; valid only with `fe_ack`.
- `fe_rvalid` out 1: one-cycle pulse; `fe_data` carries new read data.
- `fe_data` out 32: fetch read data, held between pulses.
- `mem_req` in 1: mem-stage request; held until `mem_ack`.
- `mem_addr` in 32: byte address.
- `mem_write` in 1: 1 = store, 0 = load.
- `mem_wdata` in 32: store data.
- `mem_width` in 2: 00 byte, 01 half, 1x word.
- `mem_extend` in 1: sign-extend loads.
- `mem_ack`, `mem_error`, `mem_rvalid` out 1: as the fetch equivalents.
- `mem_rdata` out 32: as `fe_data`.
- `m_req` out 1: memory access strobe.
- `m_addr` out 32: memory byte address; fetch issues `{fe_addr,2'b00}`.
- `m_write`, `m_wdata`, `m_width`, `m_extend` out: forwarded from the granted requester; fetch issues `m_write=0`, `m_width=2'b10`, `m_extend=0`.
- `m_error` in 1: combinational access fault for `m_addr`.
- `m_rdata` in 32: read data; valid the cycle after an accepted read.

## Operation
- Grant is combinational each cycle:
  - Only one requester active: that requester is granted.
  - Both active: mem is granted unless `starve_cnt == STARVE_LIMIT`, in which case fetch is granted.
- `m_*` outputs are muxed from the granted requester. With no grant, `m_req=0` and the other `m_*` outputs are don't-care.
- `m_req = grant_any & ~m_error`.
- `x_ack = granted_x`. `x_error = granted_x & m_error`. A faulted access is never issued to memory.
- `starve_cnt` width is `$clog2(STARVE_LIMIT+1)`.
  - Increments when `fe_req & mem_req` and mem is granted.
  - Clears when fetch is granted or `fe_req=0`.
  - Saturates at `STARVE_LIMIT`.
- `owner_r` register, of type `owner_e`, takes one of NONE, FE or MEM:
  - Loads FE or MEM on an issued read (`m_req & ~m_write`).
  - Loads NONE otherwise, including on writes and faults.
- Response cycle:
  - If `owner_r == FE`: `fe_rvalid=1`, `fe_data=m_rdata` (combinational bypass), and `fe_data_r <= m_rdata`.
  - MEM is handled the same way with `mem_*`.
  - Otherwise the outputs show the held `*_data_r`.
- Back-to-back reads are supported every cycle. The response for access N coincides with the grant of access N+1.

## Timing
- Ack latency is 0 cycles: `ack` is asserted in the same cycle as `req` when granted.
- Read data latency is 1 cycle after ack, via `rvalid`.
- Writes produce no `rvalid`.
- Reset values:
  - `owner_r=NONE`, `starve_cnt=0`, `fe_data_r=0`, `mem_data_r=0`.
  - Outputs with no requests: all acks/errors/rvalids 0, `m_req=0`, `fe_data=0`, `mem_rdata=0`.
- Reset asserted while a read is outstanding: `owner_r` clears immediately and no `rvalid` is produced for that read.
- Reset release: the first grant is possible in the first cycle with `reset=0`.
- A requester dropping `req` without an ack is illegal. It is not checked and produces no response.
- Simultaneous write by mem and read by fetch: this is a conflict and follows the arbitration rules above. There is no write-read ordering hazard, because a single port serialises accesses.

## Structure
- `mem_arb_pkg` holds:
  - `owner_e` enum (NONE, FE, MEM).
  - Width localparams `WIDTH_BYTE`, `WIDTH_HALF`, `WIDTH_WORD`, shared with the memory block.
- Single module; no sub-module is warranted. The grant logic, counter and response routing total about 150 lines.

## Test plan
- Fetch-only read, `fe_addr=0x4`, memory word 0xDEADBEEF:
  - Cycle 0: `fe_ack=1`, `m_addr=0x10`.
  - Cycle 1: `fe_rvalid=1`, `fe_data=0xDEADBEEF`.
  - `fe_data` stays 0xDEADBEEF afterwards.
- `fe_req` and mem load both held continuously, `STARVE_LIMIT=4`:
  - `mem_ack` for 4 cycles, then `fe_ack` in cycle 5.
  - Pattern repeats with period 5.
  - Each `rvalid` goes to the correct requester one cycle after its ack.
- Mem store, byte width, `mem_addr=0x3`, `wdata=0xAB`:
  - Same cycle: `mem_ack=1`, `m_write=1`, `m_width=00`.
  - Next cycle: `mem_rvalid=0`, `owner_r=NONE`.
- `fe_addr` giving byte address 0x0001_0000 (memory raises `m_error`):
  - Same cycle: `fe_ack=1`, `fe_error=1`, `m_req=0`.
  - No `fe_rvalid`; `fe_data` unchanged.
- Fetch read acked in cycle 0, `reset` pulsed mid-cycle 0 to 1:
  - `owner_r` goes to NONE asynchronously.
  - No `fe_rvalid` in cycle 1; `fe_data=0`.
- Alternating back-to-back reads (mem 0x100, fetch 0x200, mem 0x104), no stalls:
  - One ack per cycle.
  - Each `rvalid` pulse is routed to the requester that issued the read one cycle earlier, carrying that address's data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and width codes for the memory port arbiter
package mem_arb_pkg;

  // Which requester owns the read response arriving next cycle
  typedef enum logic [1:0] {
    NONE = 2'd0,
    FE   = 2'd1,
    MEM  = 2'd2
  } owner_e;

  // Access width codes, shared with the memory block
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, mem-stage and memory-port bundle around the arbiter
interface mem_arbiter_if;

  // fetch stage
  logic        fe_req;
  logic [31:2] fe_addr;
  logic        fe_ack;
  logic        fe_error;
  logic        fe_rvalid;
  logic [31:0] fe_data;

  // mem stage
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_width;
  logic        mem_extend;
  logic        mem_ack;
  logic        mem_error;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // unified memory port
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_write;
  logic [31:0] m_wdata;
  logic [1:0]  m_width;
  logic        m_extend;
  logic        m_error;
  logic [31:0] m_rdata;

  // arbiter side
  modport slave (
    input  fe_req, fe_addr,
    output fe_ack, fe_error, fe_rvalid, fe_data,
    input  mem_req, mem_addr, mem_write, mem_wdata, mem_width, mem_extend,
    output mem_ack, mem_error, mem_rvalid, mem_rdata,
    output m_req, m_addr, m_write, m_wdata, m_width, m_extend,
    input  m_error, m_rdata
  );

  // pipeline stages plus memory side
  modport master (
    output fe_req, fe_addr,
    input  fe_ack, fe_error, fe_rvalid, fe_data,
    output mem_req, mem_addr, mem_write, mem_wdata, mem_width, mem_extend,
    input  mem_ack, mem_error, mem_rvalid, mem_rdata,
    input  m_req, m_addr, m_write, m_wdata, m_width, m_extend,
    output m_error, m_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/mem-stage arbiter for a single-port memory with starvation guard
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int              CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_next;
  owner_e        owner_r;
  owner_e        owner_next;
  logic [31:0]   fe_data_r;
  logic [31:0]   mem_data_r;

  logic grant_fe;
  logic grant_mem;
  logic grant_any;
  logic fe_resp;
  logic mem_resp;

  // Mem stage wins conflicts unless fetch has lost STARVE_LIMIT times in a row
  always_comb begin
    grant_fe  = bus.fe_req & (~bus.mem_req | (starve_cnt == LIMIT));
    grant_mem = bus.mem_req & ~grant_fe;
    grant_any = grant_fe | grant_mem;
  end

  // Memory port mux; fetch is always a word load
  always_comb begin
    bus.m_addr   = {bus.fe_addr, 2'b00};
    bus.m_write  = 1'b0;
    bus.m_wdata  = '0;
    bus.m_width  = WIDTH_WORD;
    bus.m_extend = 1'b0;
    if (grant_mem) begin
      bus.m_addr   = bus.mem_addr;
      bus.m_write  = bus.mem_write;
      bus.m_wdata  = bus.mem_wdata;
      bus.m_width  = bus.mem_width;
      bus.m_extend = bus.mem_extend;
    end
    // A faulting access never reaches the memory
    bus.m_req = grant_any & ~bus.m_error;
  end

  // Acks and faults are reported in the grant cycle
  always_comb begin
    bus.fe_ack    = grant_fe;
    bus.fe_error  = grant_fe & bus.m_error;
    bus.mem_ack   = grant_mem;
    bus.mem_error = grant_mem & bus.m_error;
  end

  // Next owner of the response slot and next starvation count
  always_comb begin
    owner_next = NONE;
    if (bus.m_req && !bus.m_write) begin
      owner_next = grant_fe ? FE : MEM;
    end
    starve_next = starve_cnt;
    if (!bus.fe_req || grant_fe) begin
      starve_next = '0;
    end else if (grant_mem && (starve_cnt != LIMIT)) begin
      starve_next = starve_cnt + CW'(1);
    end
  end

  // Owner and starvation state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r    <= NONE;
      starve_cnt <= '0;
    end else begin
      owner_r    <= owner_next;
      starve_cnt <= starve_next;
    end
  end

  // Capture response data so each requester sees its last read held stable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fe_data_r  <= '0;
      mem_data_r <= '0;
    end else begin
      if (fe_resp) begin
        fe_data_r <= bus.m_rdata;
      end
      if (mem_resp) begin
        mem_data_r <= bus.m_rdata;
      end
    end
  end

  // Route the returning read data to its owner, bypassing the hold register
  always_comb begin
    fe_resp        = (owner_r == FE);
    mem_resp       = (owner_r == MEM);
    bus.fe_rvalid  = fe_resp;
    bus.mem_rvalid = mem_resp;
    bus.fe_data    = fe_resp ? bus.m_rdata : fe_data_r;
    bus.mem_rdata  = mem_resp ? bus.m_rdata : mem_data_r;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LIMIT = 4;

  typedef struct {
    logic [1:0]  kind;  // 0 none, 1 fetch, 2 mem
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'h4) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0] ^ 16'h3C5A};
  endfunction

  // memory: faults above 64 KiB, one-cycle read latency
  assign bus.m_error = (bus.m_addr >= 32'h0001_0000);
  always @(posedge clk) begin
    if (bus.m_req && !bus.m_write) bus.m_rdata <= mem_word(bus.m_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard
  resp_t       sb[$];
  resp_t       cur;
  resp_t       nxt;
  logic [31:0] fe_hold;
  logic [31:0] mem_hold;
  int          mcnt;
  logic        gfe;
  logic        gmem;
  logic        eerr;
  logic [31:0] eaddr;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      sb.delete();
      fe_hold  = '0;
      mem_hold = '0;
      mcnt     = 0;
    end else begin
      cur.kind = 2'd0;
      cur.data = '0;
      if (sb.size() > 0) cur = sb.pop_front();
      check("fe_rvalid", bus.fe_rvalid, cur.kind == 2'd1);
      check("mem_rvalid", bus.mem_rvalid, cur.kind == 2'd2);
      if (cur.kind == 2'd1) fe_hold = cur.data;
      if (cur.kind == 2'd2) mem_hold = cur.data;
      check("fe_data", bus.fe_data, fe_hold);
      check("mem_rdata", bus.mem_rdata, mem_hold);

      gfe   = bus.fe_req && (!bus.mem_req || mcnt == LIMIT);
      gmem  = bus.mem_req && !gfe;
      eaddr = gfe ? {bus.fe_addr, 2'b00} : bus.mem_addr;
      eerr  = (gfe || gmem) && (eaddr >= 32'h0001_0000);
      check("fe_ack", bus.fe_ack, gfe);
      check("mem_ack", bus.mem_ack, gmem);
      check("fe_error", bus.fe_error, gfe && eerr);
      check("mem_error", bus.mem_error, gmem && eerr);
      check("m_req", bus.m_req, (gfe || gmem) && !eerr);
      if (gfe) begin
        check("m_addr_fe", bus.m_addr, eaddr);
        check("m_write_fe", bus.m_write, 1'b0);
        check("m_width_fe", bus.m_width, WIDTH_WORD);
        check("m_extend_fe", bus.m_extend, 1'b0);
      end
      if (gmem) begin
        check("m_addr_mem", bus.m_addr, eaddr);
        check("m_write_mem", bus.m_write, bus.mem_write);
        check("m_width_mem", bus.m_width, bus.mem_width);
        check("m_extend_mem", bus.m_extend, bus.mem_extend);
        if (bus.mem_write) check("m_wdata", bus.m_wdata, bus.mem_wdata);
      end

      nxt.kind = 2'd0;
      nxt.data = mem_word(eaddr);
      if ((gfe || gmem) && !eerr && !(gmem && bus.mem_write)) nxt.kind = gfe ? 2'd1 : 2'd2;
      sb.push_back(nxt);

      if (!bus.fe_req || gfe) mcnt = 0;
      else if (gmem && mcnt < LIMIT) mcnt = mcnt + 1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    bus.fe_req  = 1'b0;
    bus.mem_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic fe_acked;
  logic mem_acked;

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.fe_req     = 1'b0;
    bus.fe_addr    = '0;
    bus.mem_req    = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_write  = 1'b0;
    bus.mem_wdata  = '0;
    bus.mem_width  = WIDTH_WORD;
    bus.mem_extend = 1'b0;
    bus.m_rdata    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_owner", 32'(dut.owner_r), 32'(NONE));
    check("rst_cnt", 32'(dut.starve_cnt), 32'd0);
    reset = 1'b0;
    repeat (2) next_cycle();

    // fetch-only read of word 0x10
    bus.fe_req  = 1'b1;
    bus.fe_addr = 30'h4;
    @(negedge clk);
    check("t1_ack", bus.fe_ack, 1'b1);
    check("t1_maddr", bus.m_addr, 32'h10);
    next_cycle();
    drop_reqs();
    @(negedge clk);
    check("t1_rvalid", bus.fe_rvalid, 1'b1);
    check("t1_data", bus.fe_data, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk);
    check("t1_hold", bus.fe_data, 32'hDEADBEEF);

    // fetch fault at byte address 0x1_0000
    next_cycle();
    bus.fe_req  = 1'b1;
    bus.fe_addr = 30'h4000;
    @(negedge clk);
    check("flt_ack", bus.fe_ack, 1'b1);
    check("flt_err", bus.fe_error, 1'b1);
    check("flt_mreq", bus.m_req, 1'b0);
    next_cycle();
    drop_reqs();
    @(negedge clk);
    check("flt_rvalid", bus.fe_rvalid, 1'b0);
    check("flt_hold", bus.fe_data, 32'hDEADBEEF);

    // byte store
    next_cycle();
    bus.mem_req   = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_addr  = 32'h3;
    bus.mem_wdata = 32'hAB;
    bus.mem_width = WIDTH_BYTE;
    @(negedge clk);
    check("st_ack", bus.mem_ack, 1'b1);
    check("st_write", bus.m_write, 1'b1);
    check("st_width", bus.m_width, 2'b00);
    next_cycle();
    drop_reqs();
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("st_rvalid", bus.mem_rvalid, 1'b0);
    check("st_owner", 32'(dut.owner_r), 32'(NONE));

    // sustained conflict: four mem grants then one fetch grant
    next_cycle();
    bus.fe_req    = 1'b1;
    bus.fe_addr   = 30'h80;
    bus.mem_req   = 1'b1;
    bus.mem_addr  = 32'h100;
    bus.mem_width = WIDTH_WORD;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("stv_fe", bus.fe_ack, (i % 5) == 4);
      check("stv_mem", bus.mem_ack, (i % 5) != 4);
      next_cycle();
    end
    drop_reqs();
    next_cycle();

    // reset hits while a fetch read is outstanding
    bus.fe_req  = 1'b1;
    bus.fe_addr = 30'h4;
    @(negedge clk);
    check("rr_ack", bus.fe_ack, 1'b1);
    @(posedge clk);
    #1;
    drop_reqs();
    reset = 1'b1;
    #1;
    check("rr_owner", 32'(dut.owner_r), 32'(NONE));
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rr_rvalid", bus.fe_rvalid, 1'b0);
    check("rr_data", bus.fe_data, 32'h0);

    // alternating back-to-back reads
    next_cycle();
    bus.mem_req  = 1'b1;
    bus.mem_addr = 32'h100;
    @(negedge clk);
    check("alt0_ack", bus.mem_ack, 1'b1);
    next_cycle();
    bus.mem_req = 1'b0;
    bus.fe_req  = 1'b1;
    bus.fe_addr = 30'h80;
    @(negedge clk);
    check("alt1_ack", bus.fe_ack, 1'b1);
    check("alt1_rsp", bus.mem_rdata, mem_word(32'h100));
    next_cycle();
    bus.fe_req   = 1'b0;
    bus.mem_req  = 1'b1;
    bus.mem_addr = 32'h104;
    @(negedge clk);
    check("alt2_ack", bus.mem_ack, 1'b1);
    check("alt2_rsp", bus.fe_data, mem_word(32'h200));
    next_cycle();
    drop_reqs();
    @(negedge clk);
    check("alt3_rsp", bus.mem_rdata, mem_word(32'h104));

    // random traffic, each request held until acked
    fe_acked  = 1'b0;
    mem_acked = 1'b0;
    for (int i = 0; i < 80; i++) begin
      next_cycle();
      if (!bus.fe_req || fe_acked) begin
        bus.fe_req  = ($urandom_range(0, 2) != 0);
        bus.fe_addr = ($urandom_range(0, 5) == 0) ? 30'h4000 : 30'($urandom_range(0, 255));
      end
      if (!bus.mem_req || mem_acked) begin
        bus.mem_req    = ($urandom_range(0, 3) != 0);
        bus.mem_addr   = ($urandom_range(0, 5) == 0) ? 32'h0001_0004 : 32'($urandom_range(0, 4095));
        bus.mem_write  = ($urandom_range(0, 2) == 0);
        bus.mem_wdata  = $urandom;
        bus.mem_width  = 2'($urandom_range(0, 3));
        bus.mem_extend = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      fe_acked  = bus.fe_ack;
      mem_acked = bus.mem_ack;
    end
    next_cycle();
    drop_reqs();
    repeat (3) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
